// File: rtl/seq_cmp32_ctrl.sv
// Sequencer for a bit-serial MSB-first comparator: latches two operands, streams
// them into the comparator one bit per clock, exits early once it has decided, and latches lt/eq/gt.
module seq_cmp32_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a_word,
  input  logic [WIDTH-1:0] b_word,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt,
  output logic             cmp_rst,
  output logic             cmp_op,
  output logic             cmp_a,
  output logic             cmp_b,
  input  logic             cmp_l,
  input  logic             cmp_e,
  input  logic             cmp_g,
  output logic [2:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);

  // Handshake: start is a level sampled at the rising edge. It is honoured only while
  // the sequencer is in IDLE or DONE and ignored while busy is high. done is a one-cycle
  // pulse, and lt/eq/gt hold from that cycle until the next capture.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_SHIFT = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             cmp_rst_q, cmp_rst_d;
  logic             accept;
  logic [WIDTH-1:0] msb_mask;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign msb_mask = {sgn, {(WIDTH-1){1'b0}}};

  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    cnt_d     = cnt_q;
    lt_d      = lt_q;
    eq_d      = eq_q;
    gt_d      = gt_q;
    busy      = 1'b0;
    done      = 1'b0;
    cmp_op    = 1'b1;
    cmp_a     = 1'b0;
    cmp_b     = 1'b0;
    accept    = 1'b0;

    case (state_q)
      S_IDLE: accept = start;
      S_CLR: begin
        busy    = 1'b1;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        busy   = 1'b1;
        cmp_op = 1'b0;
        cmp_a  = opa_q[cnt_q];
        cmp_b  = opb_q[cnt_q];
        cnt_d  = cnt_q - 1'b1;
        // A decided comparator wins over the last-bit exit.
        if (cmp_l || cmp_g) begin
          lt_d    = cmp_l;
          eq_d    = 1'b0;
          gt_d    = cmp_g;
          state_d = S_DONE;
        end else if (cnt_q == '0) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        busy    = 1'b1;
        lt_d    = cmp_l;
        eq_d    = cmp_e;
        gt_d    = cmp_g;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        accept  = start;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      opa_d   = a_word ^ msb_mask;
      opb_d   = b_word ^ msb_mask;
      cnt_d   = CW'(WIDTH - 1);
      state_d = S_CLR;
    end

    cmp_rst_d = (state_d == S_CLR);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      opa_q     <= '0;
      opb_q     <= '0;
      cnt_q     <= '0;
      lt_q      <= 1'b0;
      eq_q      <= 1'b0;
      gt_q      <= 1'b0;
      cmp_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      cnt_q     <= cnt_d;
      lt_q      <= lt_d;
      eq_q      <= eq_d;
      gt_q      <= gt_d;
      cmp_rst_q <= cmp_rst_d;
    end
  end

  assign lt        = lt_q;
  assign eq        = eq_q;
  assign gt        = gt_q;
  assign cmp_rst   = cmp_rst_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_cmp32_ctrl.sv
// Bench for seq_cmp32_ctrl: a registered serial comparator drives the DUT, and every cycle
// of each compare is checked against expectations derived from plain arithmetic on the operands.
module tb_seq_cmp32_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sgn;
  logic [W-1:0] a_word;
  logic [W-1:0] b_word;
  logic         busy, done, lt, eq, gt;
  logic         cmp_rst, cmp_op, cmp_a, cmp_b;
  logic         cmp_l = 1'b0, cmp_e = 1'b0, cmp_g = 1'b0;
  logic [2:0]   dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [1:0] exp_q[$];
  logic p_lt = 1'b0, p_eq = 1'b0, p_gt = 1'b0;

  seq_cmp32_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sgn(sgn),
    .a_word(a_word), .b_word(b_word),
    .busy(busy), .done(done), .lt(lt), .eq(eq), .gt(gt),
    .cmp_rst(cmp_rst), .cmp_op(cmp_op), .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_l(cmp_l), .cmp_e(cmp_e), .cmp_g(cmp_g),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Serial comparator: clears on cmp_rst, freezes on cmp_op, and sticks once decided.
  always @(posedge clk) begin
    if (cmp_rst) begin
      cmp_l <= 1'b0; cmp_e <= 1'b0; cmp_g <= 1'b0;
    end else if (!cmp_op && !(cmp_l || cmp_g)) begin
      if (cmp_a && !cmp_b) begin
        cmp_g <= 1'b1; cmp_e <= 1'b0;
      end else if (!cmp_a && cmp_b) begin
        cmp_l <= 1'b1; cmp_e <= 1'b0;
      end else begin
        cmp_e <= 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_res"}, 32'({lt, eq, gt}), 32'd0);
    check({tag, "_cmp_rst"}, 32'(cmp_rst), 32'd1);
    check({tag, "_cmp_op"}, 32'(cmp_op), 32'd1);
    check({tag, "_cmp_ab"}, 32'({cmp_a, cmp_b}), 32'd0);
  endtask

  // Checks one idle cycle, then presents a start for the next edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_cmp_rst", 32'(cmp_rst), 32'd0);
    check("idle_cmp_op", 32'(cmp_op), 32'd1);
    start = 1'b1; a_word = a; b_word = b; sgn = s;
  endtask

  // Expects start with (a,b,s) to be presented for the coming edge (cycle 0 acceptance).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input bit noise, input bit chain,
                        input logic [W-1:0] na, input logic [W-1:0] nb, input logic ns);
    logic [W-1:0] ua, ub, diff;
    logic e_lt, e_eq, e_gt;
    logic [1:0] bits;
    int hi, done_cyc, shift_end;
    e_lt = s ? ($signed(a) < $signed(b)) : (a < b);
    e_gt = s ? ($signed(a) > $signed(b)) : (a > b);
    e_eq = (a == b);
    ua = a; ub = b;
    if (s) begin
      ua[W-1] = ~ua[W-1];
      ub[W-1] = ~ub[W-1];
    end
    diff = ua ^ ub;
    hi = -1;
    for (int k = 0; k < W; k++) if (diff[k]) hi = k;
    done_cyc  = (hi < 0) ? W + 3 : W + 3 - hi;
    shift_end = (hi <= 0) ? W + 1 : done_cyc - 1;
    exp_q.delete();
    for (int k = W - 1; k >= W + 1 - shift_end; k--) exp_q.push_back({ua[k], ub[k]});

    @(posedge clk);
    for (int n = 1; n <= done_cyc; n++) begin
      @(negedge clk);
      check("busy", 32'(busy), 32'(n < done_cyc));
      check("done", 32'(done), 32'(n == done_cyc));
      check("cmp_rst", 32'(cmp_rst), 32'(n == 1));
      check("cmp_op", 32'(cmp_op), 32'(!(n >= 2 && n <= shift_end)));
      if (n >= 2 && n <= shift_end) begin
        bits = exp_q.pop_front();
        check("cmp_a", 32'(cmp_a), 32'(bits[1]));
        check("cmp_b", 32'(cmp_b), 32'(bits[0]));
      end else begin
        check("cmp_ab_quiet", 32'({cmp_a, cmp_b}), 32'd0);
      end
      if (n == done_cyc) check("result", 32'({lt, eq, gt}), 32'({e_lt, e_eq, e_gt}));
      else               check("result_hold", 32'({lt, eq, gt}), 32'({p_lt, p_eq, p_gt}));
      if (n < done_cyc) begin
        start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        if (noise) begin
          a_word = $urandom; b_word = $urandom; sgn = 1'($urandom);
        end
      end else begin
        start = chain;
        if (chain) begin
          a_word = na; b_word = nb; sgn = ns;
        end
      end
    end
    p_lt = e_lt; p_eq = e_eq; p_gt = e_gt;
  endtask

  function automatic logic [W-1:0] pick_b(input logic [W-1:0] a, input int mode);
    logic [W-1:0] r;
    case (mode)
      0:       r = $urandom;
      1:       r = a;
      default: begin
        r = a;
        r[$urandom_range(0, W - 1)] ^= 1'b1;
      end
    endcase
    return r;
  endfunction

  initial begin
    logic [W-1:0] ca, cb, na, nb;
    logic cs, ns;
    bit pend, ch;

    rst = 1'b0; start = 1'b0; sgn = 1'b0; a_word = '0; b_word = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b1;

    // Reset asserted for two cycles in the middle of a long compare.
    launch(32'h1234_5670, 32'h1234_5671, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst1");
    @(negedge clk);
    check_reset_outputs("rst2");
    rst = 1'b1;
    p_lt = 1'b0; p_eq = 1'b0; p_gt = 1'b0;
    launch(32'd5, 32'd5, 1'b0);
    run_op(32'd5, 32'd5, 1'b0, 0, 0, '0, '0, 1'b0);

    launch(32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
    run_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 0, 0, '0, '0, 1'b0);
    launch(32'h1234_5670, 32'h1234_5671, 1'b0);
    run_op(32'h1234_5670, 32'h1234_5671, 1'b0, 0, 0, '0, '0, 1'b0);
    launch(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 0, 0, '0, '0, 1'b0);
    launch(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 0, '0, '0, 1'b0);

    // Starts during busy are ignored; a start in the done cycle chains directly.
    launch(32'hDEAD_BEEF, 32'hDEAD_BEEE, 1'b1);
    run_op(32'hDEAD_BEEF, 32'hDEAD_BEEE, 1'b1, 1, 1, 32'h0000_0010, 32'h0000_0010, 1'b0);
    run_op(32'h0000_0010, 32'h0000_0010, 1'b0, 1, 1, 32'h4000_0000, 32'hC000_0000, 1'b1);
    run_op(32'h4000_0000, 32'hC000_0000, 1'b1, 0, 0, '0, '0, 1'b0);

    ca = $urandom; cb = pick_b(ca, 2); cs = 1'($urandom);
    pend = 0;
    for (int i = 0; i < 24; i++) begin
      na = $urandom;
      nb = pick_b(na, $urandom_range(0, 2));
      ns = 1'($urandom);
      ch = (i < 23) && ($urandom_range(0, 1) == 1);
      if (!pend) launch(ca, cb, cs);
      run_op(ca, cb, cs, bit'($urandom_range(0, 1)), ch, na, nb, ns);
      pend = ch;
      ca = na; cb = nb; cs = ns;
    end

    @(negedge clk);
    check("final_idle", 32'({busy, done}), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
